// File: rtl/nn_pkg.sv
// Shared widths, activation limits and state encoding for the neuron accumulator.
package nn_pkg;

  localparam int unsigned PROD_W  = 16;
  localparam int unsigned ACT_W   = 8;
  localparam int          ACT_MAX = 127;
  localparam int          ACT_MIN = -128;

  typedef enum logic [1:0] {
    S_ACC = 2'd0,
    S_FIN = 2'd1,
    S_OUT = 2'd2
  } nacc_state_t;

  typedef logic signed [ACT_W-1:0] act_t;

endpackage

// File: rtl/requant_sat.sv
// Combinational requantizer: round-half-up, arithmetic right shift, saturate to int8.
// Optional ReLU clamp when RELU_EN is defined.
module requant_sat
  import nn_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int SHIFT = 7
) (
  input  logic signed [ACC_W:0] sum,
  output act_t                  act_c,
  output logic                  sat_c
);

  localparam int unsigned TW = ACC_W + 2;
  localparam logic signed [TW-1:0] RND =
    (SHIFT > 0) ? (TW'(1) <<< ((SHIFT > 0) ? SHIFT - 1 : 0)) : TW'(0);
  localparam logic signed [TW-1:0] Y_MAX = TW'(ACT_MAX);
  localparam logic signed [TW-1:0] Y_MIN = TW'(ACT_MIN);

  logic signed [TW-1:0] t;
  logic signed [TW-1:0] y;

  // One guard bit above the sum keeps the rounding add from wrapping.
  always_comb begin
    t     = $signed({sum[ACC_W], sum}) + RND;
    y     = t >>> SHIFT;
    sat_c = 1'b0;
    act_c = act_t'(y[ACT_W-1:0]);
    if (y > Y_MAX) begin
      act_c = act_t'(ACT_MAX);
      sat_c = 1'b1;
    end else if (y < Y_MIN) begin
      act_c = act_t'(ACT_MIN);
      sat_c = 1'b1;
    end
`ifdef RELU_EN
    if (act_c[ACT_W-1]) begin
      act_c = '0;
    end
`else
`endif
  end

endmodule

// File: rtl/neuron_acc8.sv
// Neuron accumulator: sums N_INPUTS signed products plus bias, requantizes to int8.
// Build option: define RELU_EN to clamp negative activations to zero.
module neuron_acc8
  import nn_pkg::*;
#(
  parameter int N_INPUTS = 4,
  parameter int ACC_W    = 24,
  parameter int SHIFT    = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] prod,
  input  logic signed [PROD_W-1:0] bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output act_t                     out_act,
  output logic                     out_sat
);

  localparam int unsigned CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

  if (N_INPUTS < 1) begin : g_n_inputs_check
    $error("N_INPUTS must be at least 1");
  end
  if (ACC_W < 17 + $clog2(N_INPUTS)) begin : g_acc_w_check
    $error("ACC_W too small to hold N_INPUTS products without overflow");
  end
  if (SHIFT < 0 || SHIFT > ACC_W - 2) begin : g_shift_check
    $error("SHIFT out of range 0..ACC_W-2");
  end

  nacc_state_t             state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  act_t                    out_act_q, out_act_d;
  logic                    out_sat_q, out_sat_d;

  logic signed [ACC_W:0]   sum_c;
  act_t                    act_c;
  logic                    sat_c;

  assign sum_c = $signed({acc_q[ACC_W-1], acc_q})
               + $signed({{(ACC_W + 1 - PROD_W){bias[PROD_W-1]}}, bias});

  requant_sat #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_requant (
    .sum   (sum_c),
    .act_c (act_c),
    .sat_c (sat_c)
  );

  // Next-state and output logic; clr overrides any handshake in flight.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_act_d   = out_act_q;
    out_sat_d   = out_sat_q;
    if (clr) begin
      state_d     = S_ACC;
      acc_d       = '0;
      cnt_d       = '0;
      out_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        S_ACC: begin
          if (in_valid && in_ready_q) begin
            acc_d = acc_q + $signed({{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod});
            if (cnt_q == CNT_W'(N_INPUTS - 1)) begin
              cnt_d   = '0;
              state_d = S_FIN;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
        S_FIN: begin
          out_act_d   = act_c;
          out_sat_d   = sat_c;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
        S_OUT: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
            state_d     = S_ACC;
          end
        end
        default: begin
          state_d = S_ACC;
        end
      endcase
    end
    in_ready_d = (state_d == S_ACC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_ACC;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_act_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_act_q   <= out_act_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_act   = out_act_q;
  assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_neuron_acc8.sv
// Scoreboard bench for neuron_acc8 (N_INPUTS=4, ACC_W=24, SHIFT=7); honours RELU_EN.
module tb_neuron_acc8;

  typedef struct packed {
    logic signed [7:0] act;
    logic              sat;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               clr = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [15:0] prod = '0;
  logic signed [15:0] bias = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [7:0]  out_act;
  logic               out_sat;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  neuron_acc8 #(.N_INPUTS(4), .ACC_W(24), .SHIFT(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .prod      (prod),
    .bias      (bias),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_act   (out_act),
    .out_sat   (out_sat)
  );

  function automatic exp_t model(input int s, input int b);
    int   t;
    int   y;
    exp_t e;
    t     = s + b + 64;
    y     = t >>> 7;
    e.sat = 1'b0;
    if (y > 127) begin
      y = 127; e.sat = 1'b1;
    end else if (y < -128) begin
      y = -128; e.sat = 1'b1;
    end
`ifdef RELU_EN
    if (y < 0) y = 0;
`endif
    e.act = 8'(y);
    return e;
  endfunction

  function automatic exp_t mk(input int a, input logic s);
    exp_t e;
    e.act = 8'(a);
    e.sat = s;
    return e;
  endfunction

  task automatic push_prod(input int p);
    int n;
    n = 0;
    in_valid = 1'b1;
    prod     = 16'(p);
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic push4(input int p0, input int p1, input int p2, input int p3);
    push_prod(p0); push_prod(p1); push_prod(p2); push_prod(p3);
  endtask

  task automatic wait_valid(input string name, output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    ok = out_valid;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s valid_timeout: out_valid=%0b required 1", name, out_valid);
    end
  endtask

  task automatic expect_out(input string name);
    bit   ok;
    exp_t e;
    out_ready = 1'b1;
    wait_valid(name, ok);
    if (ok) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL %s unexpected_output: act=%0d with empty scoreboard", name, out_act);
      end else begin
        e = sb.pop_front();
        checks++;
        if (out_act !== e.act) begin
          errors++;
          $display("FAIL %s act: got %0d required %0d", name, out_act, e.act);
        end
        checks++;
        if (out_sat !== e.sat) begin
          errors++;
          $display("FAIL %s sat: got %0b required %0b", name, out_sat, e.sat);
        end
      end
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s post_handshake: out_valid=%0b in_ready=%0b required 0/1",
               name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_act !== 8'sd0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: valid=%0b act=%0d sat=%0b ready=%0b required 0/0/0/1",
               out_valid, out_act, out_sat, in_ready);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_latency();
    bias = 16'sd280;
    sb.push_back(mk(10, 1'b0));
    push4(100, 200, 300, 400);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: out_valid=%0b required 0 one edge after last accept", out_valid);
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL latency: out_valid=%0b required 1 two edges after last accept", out_valid);
    end
    expect_out("basic");
  endtask

  task automatic test_saturation();
    bias = 16'sd0;
    sb.push_back(mk(127, 1'b1));
    push4(16384, 16384, 16384, 16384);
    expect_out("sat_pos");
    bias = -16'sd30000;
    sb.push_back(model(-4 * 20000, -30000));
    push4(-20000, -20000, -20000, -20000);
    expect_out("sat_neg");
  endtask

  task automatic test_negative();
    bias = 16'sd0;
`ifdef RELU_EN
    sb.push_back(mk(0, 1'b0));
`else
    sb.push_back(mk(-31, 1'b0));
`endif
    push4(-1000, -1000, -1000, -1000);
    expect_out("negative");
  endtask

  task automatic test_backpressure();
    bit ok;
    bias = 16'sd280;
    out_ready = 1'b0;
    sb.push_back(mk(10, 1'b0));
    push4(100, 200, 300, 400);
    wait_valid("backpressure", ok);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_act !== 8'sd10 || out_sat !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d: valid=%0b act=%0d sat=%0b ready=%0b required 1/10/0/0",
                 i, out_valid, out_act, out_sat, in_ready);
      end
    end
    expect_out("backpressure");
    bias = 16'sd0;
    sb.push_back(mk(0, 1'b0));
    push4(1, 1, 1, 1);
    expect_out("acc_cleared");
  endtask

  task automatic test_clr();
    bias = 16'sd0;
    push_prod(5000);
    push_prod(5000);
    clr = 1'b1; in_valid = 1'b1; prod = 16'sd30000;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_state: in_ready=%0b out_valid=%0b required 1/0", in_ready, out_valid);
    end
    sb.push_back(mk(4, 1'b0));
    push4(128, 128, 128, 128);
    expect_out("after_clr");
  endtask

  task automatic test_async_reset();
    bit ok;
    bias = 16'sd0;
    out_ready = 1'b0;
    push4(9000, 9000, 9000, 9000);
    wait_valid("rst_setup", ok);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_act !== 8'sd0 || out_sat !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_rst: valid=%0b act=%0d sat=%0b ready=%0b required 0/0/0/1",
               out_valid, out_act, out_sat, in_ready);
    end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    bias = 16'sd280;
    sb.push_back(mk(10, 1'b0));
    push4(100, 200, 300, 400);
    expect_out("after_rst");
  endtask

  task automatic test_random();
    int p[4];
    int b;
    int s;
    for (int n = 0; n < 6; n++) begin
      s = 0;
      for (int i = 0; i < 4; i++) begin
        p[i] = int'($urandom_range(0, 40000)) - 20000;
        s += p[i];
      end
      b = int'($urandom_range(0, 8000)) - 4000;
      bias = 16'(b);
      sb.push_back(model(s, b));
      push4(p[0], p[1], p[2], p[3]);
      expect_out("random");
    end
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_saturation();
    test_negative();
    test_backpressure();
    test_clr();
    test_async_reset();
    test_random();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
